// File: rtl/clk_gen_prog.sv
// -----------------------------------------------------------------------------
// clk_gen_prog
//   Runtime-programmable clock generator. clk_o runs at clk_i / (2*active),
//   where active is a half-period in clk_i cycles. A new half-period is loaded
//   into a pending register. It takes effect only when a new period starts, so
//   a single period never mixes two divisors. When the block stops, the current
//   period always completes and clk_o then idles low.
//
//   Optional feature macro: CLKGEN_BURST_EN
//     When defined, the block gains a burst mode. A burst emits exactly N full
//     periods and then returns to idle. done_o pulses once at the end.
//
// Parameters
//   DIV_W         width of half_i, the active half-period and the phase counter
//   DEFAULT_HALF  active half-period after reset (1 .. 2^DIV_W-1)
//   BURST_W       width of burst_n_i (burst build only)
//
// Ports
//   clk_i       in   system clock; all logic is on its rising edge
//   rst         in   asynchronous, active-high reset
//   en          in   run request (level)
//   half_i      in   requested half-period in clk_i cycles; 0 is treated as 1
//   load_i      in   strobe that captures half_i into the pending register
//   burst_go_i  in   start a burst of burst_n_i periods (burst build only)
//   burst_n_i   in   number of periods in a burst (burst build only)
//   done_o      out  1-cycle pulse when a burst ends (burst build only)
//   clk_o       out  generated clock (registered)
//   rise_o      out  pulse in the first cycle clk_o is high
//   fall_o      out  pulse in the first cycle clk_o is low after a high phase
//   running_o   out  high while a period is in progress
//   pend_o      out  high while a loaded half-period waits to be applied
// -----------------------------------------------------------------------------
module clk_gen_prog #(
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned DEFAULT_HALF = 51,
  parameter int unsigned BURST_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] half_i,
  input  logic             load_i,
`ifdef CLKGEN_BURST_EN
  input  logic               burst_go_i,
  input  logic [BURST_W-1:0] burst_n_i,
  output logic               done_o,
`endif
  output logic             clk_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             running_o,
  output logic             pend_o
);

  // Elaboration-time sanity checks on the configuration.
  if (DEFAULT_HALF < 1 || DEFAULT_HALF > (2 ** DIV_W) - 1) begin : g_bad_default_half
    $error("clk_gen_prog: DEFAULT_HALF must be in 1 .. 2^DIV_W-1");
  end
  if (BURST_W < 1) begin : g_bad_burst_w
    $error("clk_gen_prog: BURST_W must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] active_q, active_d;
  logic [DIV_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

`ifdef CLKGEN_BURST_EN
  logic               burst_q, burst_d;
  logic [BURST_W-1:0] left_q, left_d;
  logic               done_q, done_d;
`endif

  logic start_period;
  logic keep_going;
  logic last_cycle;

  // Each phase lasts exactly active cycles: the counter runs 0 .. active-1.
  // active is never 0, so active-1 cannot wrap.
  assign last_cycle = (cnt_q == (active_q - DIV_W'(1)));

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path can leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    pend_val_d   = pend_val_q;
    pend_d       = pend_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    start_period = 1'b0;
    keep_going   = 1'b0;
`ifdef CLKGEN_BURST_EN
    burst_d      = burst_q;
    left_d       = left_q;
    done_d       = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
`ifdef CLKGEN_BURST_EN
        // A burst request takes priority over en when both arrive together.
        if (burst_go_i) begin
          if (burst_n_i == '0) begin
            done_d = 1'b1;
          end else begin
            burst_d      = 1'b1;
            left_d       = burst_n_i;
            start_period = 1'b1;
          end
        end else if (en) begin
          start_period = 1'b1;
        end
`else
        if (en) start_period = 1'b1;
`endif
      end

      S_HIGH: begin
        if (last_cycle) begin
          state_d = S_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      S_LOW: begin
        if (last_cycle) begin
          // The period is complete. en is looked at only here, so stopping
          // never truncates a phase.
          cnt_d      = '0;
          keep_going = en;
`ifdef CLKGEN_BURST_EN
          if (burst_q) begin
            left_d     = left_q - BURST_W'(1);
            keep_going = (left_q != BURST_W'(1));
            if (!keep_going) begin
              burst_d = 1'b0;
              done_d  = 1'b1;
            end
          end
`endif
          if (keep_going) start_period = 1'b1;
          else            state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A period boundary is the only place the divisor can change.
    if (start_period) begin
      state_d = S_HIGH;
      cnt_d   = '0;
      rise_d  = 1'b1;
      if (pend_q) begin
        active_d = pend_val_q;
        pend_d   = 1'b0;
      end
    end

    // A load in the same cycle as an apply leaves the new value pending.
    if (load_i) begin
      pend_val_d = (half_i == '0) ? DIV_W'(1) : half_i;
      pend_d     = 1'b1;
    end

    clk_d = (state_d == S_HIGH);
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values, whatever the order of the statements.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      active_q   <= DIV_W'(DEFAULT_HALF);
      pend_val_q <= DIV_W'(DEFAULT_HALF);
      pend_q     <= 1'b0;
      clk_q      <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

`ifdef CLKGEN_BURST_EN
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      burst_q <= 1'b0;
      left_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      burst_q <= burst_d;
      left_q  <= left_d;
      done_q  <= done_d;
    end
  end

  assign done_o = done_q;
`endif

  assign clk_o     = clk_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign running_o = (state_q != S_IDLE);
  assign pend_o    = pend_q;

endmodule

// File: tb/tb_clk_gen_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_gen_prog
//   Self-checking bench for clk_gen_prog. A behavioural model tracks the
//   position inside the current output period and the active and pending
//   half-periods. Every clk_i cycle, all outputs are compared with the model.
//   Directed steps measure phase lengths and pulse counts directly.
//   A randomized phase then exercises en and load_i, plus burst requests in
//   the CLKGEN_BURST_EN build.
// -----------------------------------------------------------------------------
module tb_clk_gen_prog;

  localparam int DIV_W        = 16;
  localparam int DEFAULT_HALF = 51;
  localparam int BURST_W      = 8;

  logic             clk_i;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] half_i;
  logic             load_i;
  logic             clk_o, rise_o, fall_o, running_o, pend_o;
`ifdef CLKGEN_BURST_EN
  logic               burst_go_i;
  logic [BURST_W-1:0] burst_n_i;
  logic               done_o;
`endif

  clk_gen_prog #(
    .DIV_W       (DIV_W),
    .DEFAULT_HALF(DEFAULT_HALF),
    .BURST_W     (BURST_W)
  ) dut (
    .clk_i     (clk_i),
    .rst       (rst),
    .en        (en),
    .half_i    (half_i),
    .load_i    (load_i),
`ifdef CLKGEN_BURST_EN
    .burst_go_i(burst_go_i),
    .burst_n_i (burst_n_i),
    .done_o    (done_o),
`endif
    .clk_o     (clk_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .running_o (running_o),
    .pend_o    (pend_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Behavioural model: m_pos is the cycle index inside the current period.
  // The clock is high for m_pos < m_act and low for the rest of the period.
  int m_run, m_pos, m_act, m_pend, m_pend_val, m_done, m_burst, m_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_act = DEFAULT_HALF;
    m_pend = 0; m_pend_val = DEFAULT_HALF;
    m_done = 0; m_burst = 0; m_left = 0;
  endtask

  // Advances the model by one clk_i edge, using the inputs sampled at that edge.
  task automatic model_step();
    int new_period;
    new_period = 0;
    m_done     = 0;
    if (m_run == 0) begin
`ifdef CLKGEN_BURST_EN
      if (burst_go_i) begin
        if (burst_n_i == 0) m_done = 1;
        else begin m_burst = 1; m_left = int'(burst_n_i); new_period = 1; end
      end else if (en) new_period = 1;
`else
      if (en) new_period = 1;
`endif
    end else begin
      m_pos++;
      if (m_pos == 2 * m_act) begin
        if (m_burst != 0) begin
          m_left--;
          if (m_left == 0) begin m_burst = 0; m_run = 0; m_done = 1; end
          else new_period = 1;
        end else if (en) new_period = 1;
        else m_run = 0;
      end
    end
    if (new_period != 0) begin
      m_run = 1;
      m_pos = 0;
      if (m_pend != 0) begin m_act = m_pend_val; m_pend = 0; end
    end
    if (load_i) begin
      m_pend_val = (half_i == 0) ? 1 : int'(half_i);
      m_pend     = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic e_clk, e_rise, e_fall;
    e_clk  = (m_run != 0) && (m_pos < m_act);
    e_rise = (m_run != 0) && (m_pos == 0);
    e_fall = (m_run != 0) && (m_pos == m_act);
    check({tag, "_clk"},     clk_o,     e_clk);
    check({tag, "_rise"},    rise_o,    e_rise);
    check({tag, "_fall"},    fall_o,    e_fall);
    check({tag, "_running"}, running_o, (m_run != 0));
    check({tag, "_pend"},    pend_o,    (m_pend != 0));
`ifdef CLKGEN_BURST_EN
    check({tag, "_done"},    done_o,    (m_done != 0));
`endif
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    check_outputs("cyc");
  endtask

  // Counts how many cycles clk_o keeps its current level, starting with this
  // cycle. Returns on the first cycle of the opposite level.
  task automatic run_len(output int n);
    logic lvl;
    lvl = clk_o;
    n   = 1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (clk_o !== lvl) break;
      n++;
    end
  endtask

  initial begin
    int n, hi, rises, falls, found;

    rst = 1'b1; en = 1'b0; half_i = '0; load_i = 1'b0;
`ifdef CLKGEN_BURST_EN
    burst_go_i = 1'b0; burst_n_i = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs("reset");
    @(negedge clk_i);
    rst = 1'b0;

    // 1: default divisor, 51 high / 51 low, rise one cycle after en.
    en = 1'b1;
    tick();
    check("t1_rise", rise_o, 1'b1);
    run_len(n); check("t1_high", n, 51);
    run_len(n); check("t1_low",  n, 51);

    // 2: load 3 mid-high; the current period stays 51/51.
    repeat (10) tick();
    half_i = 16'd3; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    check("t2_pend_set", pend_o, 1'b1);
    for (int k = 0; k < 100 && clk_o === 1'b1; k++) tick();
    run_len(n); check("t2_low_old", n, 51);
    check("t2_pend_clr", pend_o, 1'b0);
    check("t2_rise",     rise_o, 1'b1);
    run_len(n); check("t2_high_new", n, 3);
    run_len(n); check("t2_low_new",  n, 3);

    // 3: half 4, en dropped one cycle into HIGH: the period completes, then stops.
    half_i = 16'd4; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    for (int k = 0; k < 20; k++) begin tick(); if (rise_o === 1'b1) break; end
    en = 1'b0;
    hi = 1; rises = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      hi    += int'(clk_o);
      rises += int'(rise_o);
    end
    check("t3_high", hi, 4);
    check("t3_no_rise", rises, 0);
    check("t3_stopped", running_o, 1'b0);
    check("t3_clk_low", clk_o, 1'b0);

    // 4: half 0 is treated as 1, so the output has period 2.
    half_i = '0; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    en = 1'b1;
    tick();
    check("t4_rise", rise_o, 1'b1);
    rises = 0; falls = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      rises += int'(rise_o);
      falls += int'(fall_o);
    end
    check("t4_rises", rises, 5);
    check("t4_falls", falls, 5);

    // Load coinciding with a boundary: the old pending value (3) is applied,
    // and the new one (2) stays pending.
    half_i = 16'd3; load_i = 1'b1;
    tick();
    half_i = 16'd2;
    tick();
    load_i = 1'b0;
    check("simul_rise", rise_o, 1'b1);
    check("simul_pend", pend_o, 1'b1);
    run_len(n); check("simul_high3", n, 3);
    run_len(n); check("simul_low3",  n, 3);
    check("simul_pend_clr", pend_o, 1'b0);
    run_len(n); check("simul_high2", n, 2);

    // 5: asynchronous reset mid-HIGH at half 10 with a load still pending.
    half_i = 16'd10; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (rise_o === 1'b1 && pend_o === 1'b0) begin found = 1; break; end
    end
    check("t5_found_rise", found, 1);
    half_i = 16'd7; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("t5_clk",     clk_o,     1'b0);
    check("t5_pend",    pend_o,    1'b0);
    check("t5_running", running_o, 1'b0);
    check("t5_rise",    rise_o,    1'b0);
    @(negedge clk_i);
    rst = 1'b0;
    tick();
    check("t5_restart", rise_o, 1'b1);
    run_len(n); check("t5_high_default", n, 51);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      load_i = ($urandom_range(0, 24) == 0);
      half_i = 16'($urandom_range(0, 6));
`ifdef CLKGEN_BURST_EN
      burst_go_i = ($urandom_range(0, 49) == 0);
      burst_n_i  = 8'($urandom_range(0, 3));
`endif
      tick();
    end
    load_i = 1'b0;
    en     = 1'b0;

`ifdef CLKGEN_BURST_EN
    burst_go_i = 1'b0;
    // 6: a burst of 3 periods at half 2, with en low.
    for (int k = 0; k < 200 && running_o !== 1'b0; k++) tick();
    half_i = 16'd2; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    burst_n_i = 8'd3; burst_go_i = 1'b1;
    tick();
    burst_go_i = 1'b0;
    rises = int'(rise_o);
    falls = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      rises += int'(rise_o);
      falls += int'(done_o);
    end
    check("t6_rises", rises, 3);
    check("t6_done",  falls, 1);
    check("t6_clk_low", clk_o, 1'b0);
    // Burst of zero periods: no clock, done_o on the next cycle.
    burst_n_i = '0; burst_go_i = 1'b1;
    tick();
    burst_go_i = 1'b0;
    check("t6_zero_done", done_o, 1'b1);
    check("t6_zero_idle", running_o, 1'b0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
